// File: rtl/lfsr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr_pkg : shared types, widths and step function for lfsr_sched     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WARM  = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    localparam int LFSR_W = 5;
    localparam int TAP_HI = 4;
    localparam int TAP_LO = 2;

    // Fibonacci step for x^5 + x^3 + 1; never reaches zero from a non-zero state
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr5_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr5_step : 5-bit LFSR register with load and advance enable        |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module lfsr5_step
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 5'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_val_i,
    input  logic              adv_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (adv_i) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= DEFAULT_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr_sched : round-robin scheduler sharing one LFSR among requesters |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module lfsr_sched
    import lfsr_pkg::*;
#(
    parameter int                NREQ         = 4,
    parameter int                WARMUP       = 5,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 5'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [LFSR_W-1:0] rand_data_o,
    input  logic              seed_load_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic              seed_ack_o,
    output logic              seed_err_o,
    output logic              busy_o
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_q, state_d;
    logic [4:0]        warm_cnt_q, warm_cnt_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [LFSR_W-1:0] seed_q, seed_d;
    logic              zero_pend_q, zero_pend_d;
    logic              ack_pend_q, ack_pend_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [LFSR_W-1:0] rand_q, rand_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    logic              lfsr_load;
    logic              lfsr_adv;
    logic [LFSR_W-1:0] lfsr_load_val;
    logic [LFSR_W-1:0] lfsr_val;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;

    lfsr5_step #(
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (lfsr_load),
        .load_val_i (lfsr_load_val),
        .adv_i      (lfsr_adv),
        .state_o    (lfsr_val)
    );

    // First asserted request strictly after the rr pointer, wrapping at NREQ-1
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = rr_q;
        for (int off = 0; off < NREQ; off++) begin
            cand = (cand == IDX_W'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!pick_found && req_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        warm_cnt_d    = warm_cnt_q;
        rr_d          = rr_q;
        seed_d        = seed_q;
        zero_pend_d   = zero_pend_q;
        ack_pend_d    = ack_pend_q;
        gnt_d         = '0;
        rand_d        = '0;
        ack_d         = 1'b0;
        err_d         = 1'b0;
        lfsr_load     = 1'b0;
        lfsr_adv      = 1'b0;
        lfsr_load_val = (seed_q == '0) ? DEFAULT_SEED : seed_q;

        if (seed_load_i) begin
            state_d = ST_LOAD;
            seed_d  = seed_i;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    lfsr_load   = 1'b1;
                    warm_cnt_d  = '0;
                    zero_pend_d = (seed_q == '0);
                    ack_pend_d  = 1'b1;
                    state_d     = ST_WARM;
                end
                ST_WARM: begin
                    lfsr_adv = 1'b1;
                    if (warm_cnt_q == 5'(WARMUP - 1)) begin
                        // Reset-initiated warm-up has no pending load, so no ack
                        state_d     = ST_SERVE;
                        warm_cnt_d  = '0;
                        ack_d       = ack_pend_q;
                        err_d       = ack_pend_q & zero_pend_q;
                        ack_pend_d  = 1'b0;
                        zero_pend_d = 1'b0;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 5'd1;
                    end
                end
                ST_SERVE: begin
                    if (pick_found) begin
                        gnt_d    = NREQ'(1) << pick_idx;
                        rand_d   = lfsr_val;
                        lfsr_adv = 1'b1;
                        rr_d     = pick_idx;
                    end
                end
                default: begin
                    state_d = ST_WARM;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_WARM;
            warm_cnt_q  <= '0;
            rr_q        <= IDX_W'(NREQ - 1);
            seed_q      <= DEFAULT_SEED;
            zero_pend_q <= 1'b0;
            ack_pend_q  <= 1'b0;
            gnt_q       <= '0;
            rand_q      <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            rr_q        <= rr_d;
            seed_q      <= seed_d;
            zero_pend_q <= zero_pend_d;
            ack_pend_q  <= ack_pend_d;
            gnt_q       <= gnt_d;
            rand_q      <= rand_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rand_data_o = rand_q;
    assign seed_ack_o  = ack_q;
    assign seed_err_o  = err_q;
    assign busy_o      = (state_q != ST_SERVE);

endmodule
`default_nettype wire

// File: tb/tb_lfsr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lfsr_sched : self-checking bench for lfsr_sched                   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_lfsr_sched;

    localparam int         NREQ   = 4;
    localparam int         WARMUP = 5;
    localparam logic [4:0] DEF    = 5'h01;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NREQ-1:0] req_i = '0;
    logic            seed_load_i = 1'b0;
    logic [4:0]      seed_i = '0;
    logic [NREQ-1:0] gnt_o;
    logic [4:0]      rand_data_o;
    logic            seed_ack_o;
    logic            seed_err_o;
    logic            busy_o;

    lfsr_sched #(
        .NREQ         (NREQ),
        .WARMUP       (WARMUP),
        .DEFAULT_SEED (DEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .rand_data_o (rand_data_o),
        .seed_load_i (seed_load_i),
        .seed_i      (seed_i),
        .seed_ack_o  (seed_ack_o),
        .seed_err_o  (seed_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: cycles remaining until serving, owed ack, next word to issue
    int              m_busy_left;
    bit              m_ack_owed;
    bit              m_err_owed;
    logic [4:0]      m_lfsr;
    int              m_rr;
    logic [NREQ-1:0] e_gnt;
    logic [4:0]      e_rand;
    logic            e_ack, e_err, e_busy;

    function automatic logic [4:0] step(input logic [4:0] s);
        return {s[3:0], s[4] ^ s[2]};
    endfunction

    function automatic logic [4:0] stepn(input logic [4:0] s, input int n);
        logic [4:0] v;
        v = s;
        for (int k = 0; k < n; k++) v = step(v);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [NREQ-1:0] rq,
                              input logic sl, input logic [4:0] sd);
        bit done;
        int idx;
        e_gnt  = '0;
        e_rand = '0;
        e_ack  = 1'b0;
        e_err  = 1'b0;
        done   = 1'b0;
        if (!r) begin
            m_busy_left = WARMUP;
            m_ack_owed  = 1'b0;
            m_err_owed  = 1'b0;
            m_lfsr      = stepn(DEF, WARMUP);
            m_rr        = NREQ - 1;
        end else if (sl) begin
            m_busy_left = 1 + WARMUP;
            m_ack_owed  = 1'b1;
            m_err_owed  = (sd == 5'h00);
            m_lfsr      = stepn((sd == 5'h00) ? DEF : sd, WARMUP);
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0 && m_ack_owed) begin
                e_ack      = 1'b1;
                e_err      = m_err_owed;
                m_ack_owed = 1'b0;
            end
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (!done && rq[idx]) begin
                    done       = 1'b1;
                    e_gnt[idx] = 1'b1;
                    e_rand     = m_lfsr;
                    m_lfsr     = step(m_lfsr);
                    m_rr       = idx;
                end
            end
        end
        e_busy = (m_busy_left > 0);
    endtask

    task automatic cycle(input logic r, input logic [NREQ-1:0] rq,
                         input logic sl, input logic [4:0] sd);
        @(negedge clk);
        rst         = r;
        req_i       = rq;
        seed_load_i = sl;
        seed_i      = sd;
        @(posedge clk);
        model_edge(r, rq, sl, sd);
        #1;
        chk("mdl_gnt",  32'(gnt_o),       32'(e_gnt));
        chk("mdl_rand", 32'(rand_data_o), 32'(e_rand));
        chk("mdl_ack",  32'(seed_ack_o),  32'(e_ack));
        chk("mdl_err",  32'(seed_err_o),  32'(e_err));
        chk("mdl_busy", 32'(busy_o),      32'(e_busy));
    endtask

    typedef struct {
        logic            r;
        logic [NREQ-1:0] rq;
        logic            sl;
        logic [4:0]      sd;
        logic [NREQ-1:0] gnt;
        logic [4:0]      rd;
        logic            ack;
        logic            err;
        logic            busy;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        bit         seen;
        int         busy_cnt;
        int         bad;
        bit         ack_seen;
        logic [4:0] vals [32];

        // Post-reset warm-up, rotation over all requesters, then req=1010 with idle gaps
        tbl[0]  = '{1'b0, 4'h0, 1'b0, 5'h00, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 4'h0, 1'b0, 5'h00, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 4'h0, 1'b0, 5'h00, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 4'h0, 1'b0, 5'h00, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 4'h0, 1'b0, 5'h00, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 4'h0, 1'b0, 5'h00, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 4'h0, 1'b0, 5'h00, 4'h0, 5'h00, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'hF, 1'b0, 5'h00, 4'h1, 5'h05, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 4'hF, 1'b0, 5'h00, 4'h2, 5'h0B, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 4'hF, 1'b0, 5'h00, 4'h4, 5'h16, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 4'hF, 1'b0, 5'h00, 4'h8, 5'h0C, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 4'hF, 1'b0, 5'h00, 4'h1, 5'h19, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 4'h2, 1'b0, 5'h00, 4'h2, 5'h13, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 4'hA, 1'b0, 5'h00, 4'h8, 5'h07, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 4'h0, 1'b0, 5'h00, 4'h0, 5'h00, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 4'hA, 1'b0, 5'h00, 4'h2, 5'h0F, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 4'h0, 1'b0, 5'h00, 4'h0, 5'h00, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 4'hA, 1'b0, 5'h00, 4'h8, 5'h1F, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < NVEC; i++) begin
            cycle(tbl[i].r, tbl[i].rq, tbl[i].sl, tbl[i].sd);
            chk($sformatf("tbl%0d_gnt", i),  32'(gnt_o),       32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_rand", i), 32'(rand_data_o), 32'(tbl[i].rd));
            chk($sformatf("tbl%0d_ack", i),  32'(seed_ack_o),  32'(tbl[i].ack));
            chk($sformatf("tbl%0d_err", i),  32'(seed_err_o),  32'(tbl[i].err));
            chk($sformatf("tbl%0d_busy", i), 32'(busy_o),      32'(tbl[i].busy));
        end

        // Seed 1F, ack latency, then full period on requester 2
        cycle(1'b1, 4'h0, 1'b1, 5'h1F);
        lat  = 1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cycle(1'b1, 4'h0, 1'b0, 5'h00);
            lat++;
            if (seed_ack_o) seen = 1'b1;
        end
        chk("ack_latency", seen ? 32'(lat) : 32'd0, 32'd7);
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 4'h4, 1'b0, 5'h00);
            vals[i] = rand_data_o;
            chk("gnt_req2", 32'(gnt_o), 32'h4);
        end
        bad = 0;
        for (int i = 0; i < 31; i++) begin
            if (vals[i] == 5'h00) bad++;
            for (int j = 0; j < i; j++) if (vals[j] == vals[i]) bad++;
        end
        chk("distinct31", 32'(bad), 32'd0);
        chk("wrap32", 32'(vals[31]), 32'(vals[0]));
        chk("first_after_1F", 32'(vals[0]), 32'h03);

        // Zero seed: default substituted, err with ack
        cycle(1'b1, 4'h0, 1'b1, 5'h00);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cycle(1'b1, 4'h0, 1'b0, 5'h00);
            if (seed_ack_o) seen = 1'b1;
        end
        chk("zero_ack_seen", 32'(seen), 32'd1);
        chk("zero_err_with_ack", 32'(seed_err_o), 32'd1);
        cycle(1'b1, 4'hF, 1'b0, 5'h00);
        chk("zero_seed_first", 32'(rand_data_o), 32'h05);

        // seed_load colliding with requests in SERVE
        cycle(1'b1, 4'hF, 1'b0, 5'h00);
        cycle(1'b1, 4'hF, 1'b1, 5'h0A);
        chk("no_gnt_on_load", 32'(gnt_o), 32'h0);
        busy_cnt = busy_o ? 1 : 0;
        seen     = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cycle(1'b1, 4'hF, 1'b0, 5'h00);
            if (busy_o) busy_cnt++;
            else seen = 1'b1;
        end
        chk("busy_len", 32'(busy_cnt), 32'(1 + WARMUP));
        cycle(1'b1, 4'hF, 1'b0, 5'h00);
        chk("restart_seed", 32'(rand_data_o), 32'h02);

        // Reset during WARM after a load
        cycle(1'b1, 4'h0, 1'b1, 5'h07);
        cycle(1'b1, 4'h0, 1'b0, 5'h00);
        cycle(1'b1, 4'h0, 1'b0, 5'h00);
        cycle(1'b0, 4'hF, 1'b0, 5'h00);
        chk("rst_gnt",  32'(gnt_o),       32'h0);
        chk("rst_rand", 32'(rand_data_o), 32'h0);
        chk("rst_ack",  32'(seed_ack_o),  32'h0);
        chk("rst_err",  32'(seed_err_o),  32'h0);
        chk("rst_busy", 32'(busy_o),      32'h1);
        ack_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, 4'h0, 1'b0, 5'h00);
            if (seed_ack_o) ack_seen = 1'b1;
        end
        chk("no_ack_after_abort", 32'(ack_seen), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic            r;
            logic            sl;
            logic [4:0]      sd;
            logic [NREQ-1:0] rq;
            r  = ($urandom_range(0, 99) >= 2);
            sl = ($urandom_range(0, 99) < 5);
            sd = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom);
            rq = NREQ'($urandom);
            cycle(r, rq, sl, sd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
